// File: rtl/msrv32_fetch_pkg.sv
// Shared types and sizing for the msrv32 instruction fetch stage.
// Define MSRV32_FETCH_BUF2_EN for a two-entry fetch buffer; the default is one entry.
package msrv32_fetch_pkg;

`ifdef MSRV32_FETCH_BUF2_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    localparam int CNT_W = $clog2(FETCH_DEPTH + 1);

    localparam logic [31:0] RESET_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_FAULT = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // A response in flight already owns a slot, so it counts against the depth.
    function automatic logic has_credit(input logic [CNT_W-1:0] count,
                                        input logic             pop,
                                        input logic             in_wait);
        return (32'(count) + 32'(in_wait)) < (32'(FETCH_DEPTH) + 32'(pop));
    endfunction

endpackage

// File: rtl/msrv32_fetch_buf.sv
// Small in-order buffer of fetched {pc, instr} entries; head is always slot 0.
// Depth comes from msrv32_fetch_pkg (MSRV32_FETCH_BUF2_EN selects two entries).
module msrv32_fetch_buf
    import msrv32_fetch_pkg::*;
(
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     din,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    // One spare slot past the end stays zero so the shift below never reads out of range.
    fetch_entry_t     mem [FETCH_DEPTH+1];
    logic [CNT_W-1:0] wr_idx;

    assign wr_idx = count - CNT_W'(pop);
    assign head   = mem[0];

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            count <= '0;
            for (int i = 0; i <= FETCH_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clear) begin
                count <= '0;
            end else if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end

            for (int i = 0; i < FETCH_DEPTH; i++) begin
                if (push && !clear && (wr_idx == CNT_W'(i))) begin
                    mem[i] <= din;
                end else if (pop) begin
                    mem[i] <= mem[i+1];
                end
            end
        end
    end

endmodule

// File: rtl/msrv32_instr_fetch.sv
// Instruction fetch stage: issues one word read at a time for pc_in and buffers the results for decode.
// Define MSRV32_FETCH_BUF2_EN to allow a request to overlap one held instruction.
module msrv32_instr_fetch
    import msrv32_fetch_pkg::*;
(
    input  logic         ms_riscv32_mp_clk_in,
    input  logic         ms_riscv32_mp_rst_in,
    input  logic [31:0]  pc_in,
    input  logic         fetch_en_in,
    input  logic         flush_in,
    output logic         pc_hold_out,
    output logic         imem_req_out,
    output logic [31:0]  imem_addr_out,
    input  logic         imem_gnt_in,
    input  logic         imem_rvalid_in,
    input  logic [31:0]  imem_rdata_in,
    output logic         instr_valid_out,
    output logic [31:0]  instr_out,
    output logic [31:0]  instr_pc_out,
    input  logic         decode_ready_in,
    output logic         misaligned_out,
    output fetch_state_e fsm_state
);

    // Handshakes: a request is accepted in a cycle where imem_req_out & imem_gnt_in; exactly one
    // imem_rvalid_in follows in a later cycle. Decode takes the head in a cycle where
    // instr_valid_out & decode_ready_in; the head is held stable until then.
    fetch_state_e     state;
    logic [31:0]      req_pc;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     din;
    logic             aligned;
    logic             accept;
    logic             pop;
    logic             push;
    logic             credit;

    assign aligned         = (pc_in[1:0] == 2'b00);
    assign imem_req_out    = (state == S_REQ) && aligned;
    assign imem_addr_out   = pc_in;
    assign accept          = imem_req_out && imem_gnt_in;
    assign pc_hold_out     = !accept;

    assign instr_valid_out = (count != '0);
    assign pop             = instr_valid_out && decode_ready_in;
    assign push            = (state == S_WAIT) && imem_rvalid_in && !flush_in;
    assign credit          = has_credit(count, pop, state == S_WAIT);

    assign instr_out       = instr_valid_out ? head.instr : RESET_INSTR;
    assign instr_pc_out    = instr_valid_out ? head.pc : 32'h0;
    assign fsm_state       = state;

    assign din.pc          = req_pc;
    assign din.instr       = imem_rdata_in;

    msrv32_fetch_buf u_buf (
        .ms_riscv32_mp_clk_in (ms_riscv32_mp_clk_in),
        .ms_riscv32_mp_rst_in (ms_riscv32_mp_rst_in),
        .push                 (push),
        .pop                  (pop),
        .clear                (flush_in),
        .din                  (din),
        .head                 (head),
        .count                (count)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state          <= S_IDLE;
            req_pc         <= 32'h0;
            misaligned_out <= 1'b0;
        end else begin
            if (flush_in) begin
                misaligned_out <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (!flush_in && fetch_en_in && credit) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (accept) begin
                        req_pc <= pc_in;
                    end
                    if (flush_in) begin
                        state <= accept ? S_DRAIN : S_IDLE;
                    end else if (!aligned) begin
                        state          <= S_FAULT;
                        misaligned_out <= 1'b1;
                    end else if (accept) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response landing with the flush is simply dropped, so nothing is left to drain.
                    if (flush_in) begin
                        state <= imem_rvalid_in ? S_IDLE : S_DRAIN;
                    end else if (imem_rvalid_in) begin
                        state <= (fetch_en_in && credit) ? S_REQ : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid_in) begin
                        state <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    if (flush_in) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_instr_fetch.sv
// Directed self-checking bench for msrv32_instr_fetch; covers reset, fetch, stall, flush, fault and mid-transaction reset.
module tb_msrv32_instr_fetch;
  import msrv32_fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pc_in;
  logic         fetch_en_in;
  logic         flush_in;
  logic         pc_hold_out;
  logic         imem_req_out;
  logic [31:0]  imem_addr_out;
  logic         imem_gnt_in;
  logic         imem_rvalid_in;
  logic [31:0]  imem_rdata_in;
  logic         instr_valid_out;
  logic [31:0]  instr_out;
  logic [31:0]  instr_pc_out;
  logic         decode_ready_in;
  logic         misaligned_out;
  fetch_state_e fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_pop    = 0;

  logic [63:0] exp_q[$];
  logic        pend;
  logic [31:0] pend_addr;

  // clock / reset
  always #5 clk = ~clk;

  msrv32_instr_fetch dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .pc_in                (pc_in),
    .fetch_en_in          (fetch_en_in),
    .flush_in             (flush_in),
    .pc_hold_out          (pc_hold_out),
    .imem_req_out         (imem_req_out),
    .imem_addr_out        (imem_addr_out),
    .imem_gnt_in          (imem_gnt_in),
    .imem_rvalid_in       (imem_rvalid_in),
    .imem_rdata_in        (imem_rdata_in),
    .instr_valid_out      (instr_valid_out),
    .instr_out            (instr_out),
    .instr_pc_out         (instr_pc_out),
    .decode_ready_in      (decode_ready_in),
    .misaligned_out       (misaligned_out),
    .fsm_state            (fsm_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'hA000_0000 | addr;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 64'(fsm_state), 64'(S_IDLE));
    check({tag, "_req"}, 64'(imem_req_out), 64'd0);
    check({tag, "_addr"}, 64'(imem_addr_out), 64'(pc_in));
    check({tag, "_hold"}, 64'(pc_hold_out), 64'd1);
    check({tag, "_valid"}, 64'(instr_valid_out), 64'd0);
    check({tag, "_instr"}, 64'(instr_out), 64'h0000_0013);
    check({tag, "_ipc"}, 64'(instr_pc_out), 64'd0);
    check({tag, "_mis"}, 64'(misaligned_out), 64'd0);
  endtask

  // driver: one cycle of a zero-wait memory (gnt always high, rvalid the cycle after accept)
  // plus a PC register that advances by 4 on each accepted request. Called at a negedge.
  task automatic env_cycle();
    logic [63:0] exp;
    logic        acc;
    logic [31:0] nxt_pc;
    imem_gnt_in    = 1'b1;
    imem_rvalid_in = pend;
    imem_rdata_in  = mem_word(pend_addr);
    #1;
    if (instr_valid_out && decode_ready_in) begin
      n_pop++;
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else exp = '1;
      check("pop_entry", {instr_pc_out, instr_out}, exp);
    end
    if (pend) exp_q.push_back({pend_addr, mem_word(pend_addr)});
    acc = imem_req_out && imem_gnt_in;
    check("pc_hold", 64'(pc_hold_out), 64'(!acc));
    if (acc) n_acc++;
    pend      = acc;
    pend_addr = pc_in;
    nxt_pc    = acc ? pc_in + 32'd4 : pc_in;
    @(negedge clk);
    pc_in = nxt_pc;
  endtask

  initial begin
    rst = 1'b1; pc_in = 32'h0; fetch_en_in = 1'b1; flush_in = 1'b0;
    imem_gnt_in = 1'b1; imem_rvalid_in = 1'b0; imem_rdata_in = 32'h0; decode_ready_in = 1'b0;
    pend = 1'b0; pend_addr = 32'h0;

    // reset values, then first fetch from 0x0
    @(negedge clk); @(negedge clk); #1;
    check_reset("rst0");
    @(negedge clk); rst = 1'b0; #1;
    check("t1_idle", 64'(fsm_state), 64'(S_IDLE));
    @(negedge clk); #1;
    check("t1_req", 64'(imem_req_out), 64'd1);
    check("t1_addr", 64'(imem_addr_out), 64'h0);
    check("t1_hold", 64'(pc_hold_out), 64'd0);
    @(negedge clk);
    pc_in = 32'h4; imem_gnt_in = 1'b0; imem_rvalid_in = 1'b1; imem_rdata_in = 32'h0050_0093; fetch_en_in = 1'b0;
    #1;
    check("t1_wait_state", 64'(fsm_state), 64'(S_WAIT));
    check("t1_wait_hold", 64'(pc_hold_out), 64'd1);
    check("t1_wait_valid", 64'(instr_valid_out), 64'd0);
    @(negedge clk); imem_rvalid_in = 1'b0; #1;
    check("t1_valid", 64'(instr_valid_out), 64'd1);
    check("t1_instr", 64'(instr_out), 64'h0050_0093);
    check("t1_ipc", 64'(instr_pc_out), 64'h0);

    // pop and flush together: flush wins, buffer empties
    @(negedge clk); decode_ready_in = 1'b1; flush_in = 1'b1; #1;
    check("pf_valid_before", 64'(instr_valid_out), 64'd1);
    @(negedge clk); flush_in = 1'b0; decode_ready_in = 1'b0; #1;
    check("pf_valid_after", 64'(instr_valid_out), 64'd0);
    check("pf_instr_nop", 64'(instr_out), 64'h0000_0013);
    check("pf_ipc", 64'(instr_pc_out), 64'h0);

    // decode stalled for 10 cycles: at most FETCH_DEPTH requests, none lost
    pc_in = 32'h200; fetch_en_in = 1'b1;
    for (int i = 0; i < 10; i++) env_cycle();
    #1;
    check("t2_accepts", 64'(n_acc), 64'(FETCH_DEPTH));
    check("t2_full_hold", 64'(pc_hold_out), 64'd1);
    check("t2_full_req", 64'(imem_req_out), 64'd0);
    check("t2_head", {instr_pc_out, instr_out}, {32'h200, 32'hA000_0200});
    fetch_en_in = 1'b0; decode_ready_in = 1'b1;
    for (int i = 0; i < FETCH_DEPTH + 2; i++) env_cycle();
    #1;
    check("t2_pops", 64'(n_pop), 64'(FETCH_DEPTH));
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t2_valid_end", 64'(instr_valid_out), 64'd0);

    // grant at 0x8, flush next cycle, late response dropped, refetch at 0x40
    @(negedge clk);
    pc_in = 32'h8; fetch_en_in = 1'b1; decode_ready_in = 1'b1; imem_gnt_in = 1'b0; imem_rvalid_in = 1'b0;
    #1;
    check("t3_idle", 64'(fsm_state), 64'(S_IDLE));
    @(negedge clk); imem_gnt_in = 1'b1; #1;
    check("t3_req", 64'(imem_req_out), 64'd1);
    check("t3_addr", 64'(imem_addr_out), 64'h8);
    @(negedge clk); pc_in = 32'hC; imem_gnt_in = 1'b0; flush_in = 1'b1; #1;
    check("t3_wait", 64'(fsm_state), 64'(S_WAIT));
    @(negedge clk); pc_in = 32'h40; flush_in = 1'b0; #1;
    check("t3_drain", 64'(fsm_state), 64'(S_DRAIN));
    check("t3_drain_req", 64'(imem_req_out), 64'd0);
    check("t3_drain_valid", 64'(instr_valid_out), 64'd0);
    @(negedge clk); imem_rvalid_in = 1'b1; imem_rdata_in = 32'hDEAD_BEEF; #1;
    check("t3_drain_hold", 64'(fsm_state), 64'(S_DRAIN));
    @(negedge clk); imem_rvalid_in = 1'b0; #1;
    check("t3_discard_valid", 64'(instr_valid_out), 64'd0);
    check("t3_back_idle", 64'(fsm_state), 64'(S_IDLE));
    @(negedge clk); imem_gnt_in = 1'b1; #1;
    check("t3_refetch_req", 64'(imem_req_out), 64'd1);
    check("t3_refetch_addr", 64'(imem_addr_out), 64'h40);
    @(negedge clk);
    pc_in = 32'h44; imem_gnt_in = 1'b0; imem_rvalid_in = 1'b1; imem_rdata_in = 32'h0010_0113;
    fetch_en_in = 1'b0; decode_ready_in = 1'b0;
    #1;
    @(negedge clk); imem_rvalid_in = 1'b0; decode_ready_in = 1'b1; #1;
    check("t3_entry", {instr_pc_out, instr_out}, {32'h40, 32'h0010_0113});
    @(negedge clk); decode_ready_in = 1'b0; #1;
    check("t3_popped", 64'(instr_valid_out), 64'd0);

    // misaligned PC faults and holds until a flush to 0x100
    @(negedge clk); pc_in = 32'h6; fetch_en_in = 1'b1; #1;
    @(negedge clk); #1;
    check("t4_state_req", 64'(fsm_state), 64'(S_REQ));
    check("t4_no_req", 64'(imem_req_out), 64'd0);
    check("t4_hold", 64'(pc_hold_out), 64'd1);
    @(negedge clk); #1;
    check("t4_fault", 64'(fsm_state), 64'(S_FAULT));
    check("t4_mis", 64'(misaligned_out), 64'd1);
    @(negedge clk); #1;
    check("t4_mis_held", 64'(misaligned_out), 64'd1);
    check("t4_fault_no_req", 64'(imem_req_out), 64'd0);
    flush_in = 1'b1;
    @(negedge clk); flush_in = 1'b0; pc_in = 32'h100; #1;
    check("t4_mis_clr", 64'(misaligned_out), 64'd0);
    check("t4_idle", 64'(fsm_state), 64'(S_IDLE));
    @(negedge clk); imem_gnt_in = 1'b1; #1;
    check("t4_resume_req", 64'(imem_req_out), 64'd1);
    check("t4_resume_addr", 64'(imem_addr_out), 64'h100);

    // asynchronous reset while waiting on a response
    @(negedge clk); pc_in = 32'h104; imem_gnt_in = 1'b0; #1;
    check("t5_wait", 64'(fsm_state), 64'(S_WAIT));
    #2 rst = 1'b1;
    #1;
    check_reset("t5_rst");
    @(negedge clk); @(negedge clk); rst = 1'b0; fetch_en_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t5_no_stray", 64'(instr_valid_out), 64'd0);
    end
    check("t5_idle", 64'(fsm_state), 64'(S_IDLE));

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
